alu_seq_ctrl: RTL and testbench

//  Multicycle control unit that sequences the 8-bit ALU. Fetches 8-bit instructions

---
 rtl/alu_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multicycle fetch/decode/execute sequencer for an external 8-bit ALU with ACC and R0-R3.
// Define ALU_SEQ_CTRL_JZ_EN to make opcode B a two-byte JZ; otherwise B is a one-byte NOP.
module alu_seq_ctrl #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         NREGS    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   output logic [7:0] pm_addr,
   output logic       pm_rd,
   input  logic [7:0] pm_data,
   input  logic       pm_valid,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [7:0] alu_out,
   output logic [7:0] acc,
   output logic       zero,
   output logic       busy,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_OPND,
      S_EXEC,
      S_HALT
   } state_e;

   localparam logic [3:0] OPC_MOV     = 4'h8;
   localparam logic [3:0] OPC_LDI     = 4'h9;
   localparam logic [3:0] OPC_JMP     = 4'hA;
   localparam logic [3:0] OPC_JZ      = 4'hB;
   localparam logic [3:0] OPC_HLT     = 4'hF;
   localparam logic [2:0] ALU_OP_IDLE = 3'b110;

`ifdef ALU_SEQ_CTRL_JZ_EN
   localparam bit JZ_EN = 1'b1;
`else
   localparam bit JZ_EN = 1'b0;
`endif

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] op_q, op_d;
   logic [7:0] acc_q, acc_d;
   logic       z_q, z_d;
   logic [5:0] ir_q, ir_d;  // {opc, rs}; reserved bits IR[3:2] are dropped at fetch
   logic [7:0] rf_q [NREGS];
   logic [7:0] rf_d [NREGS];

   logic [3:0] opc;
   logic [1:0] rs;
   logic       two_byte;

   assign opc      = ir_q[5:2];
   assign rs       = ir_q[1:0];
   assign two_byte = (opc == OPC_LDI) || (opc == OPC_JMP) || (JZ_EN && (opc == OPC_JZ));

   assign pm_addr = pc_q;
   assign pm_rd   = (state_q == S_FETCH) || (state_q == S_OPND);
   assign alu_a   = acc_q;
   assign alu_b   = rf_q[rs];
   assign acc     = acc_q;
   assign zero    = z_q;
   assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted  = (state_q == S_HALT);

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path can infer a latch.
      state_d = state_q;
      pc_d    = pc_q;
      op_d    = op_q;
      acc_d   = acc_q;
      z_d     = z_q;
      ir_d    = ir_q;
      rf_d    = rf_q;
      alu_op  = ALU_OP_IDLE;

      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (pm_valid) begin
               ir_d    = {pm_data[7:4], pm_data[1:0]};
               pc_d    = pc_q + 8'd1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (two_byte)              state_d = S_OPND;
            else if (opc == OPC_HLT)   state_d = S_HALT;
            else                       state_d = S_EXEC;
         end
         S_OPND: begin
            if (pm_valid) begin
               op_d    = pm_data;
               pc_d    = pc_q + 8'd1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            if (!opc[3] && (opc[2:0] != 3'b111)) begin
               alu_op = opc[2:0];
               acc_d  = alu_out;
               z_d    = (alu_out == 8'h00);
            end else begin
               case (opc)
                  OPC_MOV: rf_d[rs] = acc_q;
                  OPC_LDI: acc_d    = op_q;
                  OPC_JMP: pc_d     = op_q;
                  OPC_JZ:  if (JZ_EN && z_q) pc_d = op_q;
                  default: ;
               endcase
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         op_q    <= '0;
         acc_q   <= '0;
         z_q     <= 1'b0;
         ir_q    <= '0;
         // NOTE: the register file is small and architecturally zero after reset, so it is cleared here.
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         ir_q    <= ir_d;
         rf_q    <= rf_d;
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized programs checked against an instruction-level reference model.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [7:0] pm_addr;
   logic       pm_rd;
   logic [7:0] pm_data = 8'h00;
   logic       pm_valid = 1'b0;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [2:0] alu_op;
   logic [7:0] acc;
   logic       zero, busy, halted;

   logic [7:0] mem [256];
   int         lat    = 1;
   int         rd_cnt = 0;
   bit         inj    = 1'b0;
   int         checks = 0;
   int         errors = 0;

   alu_seq_ctrl dut (
      .clk(clk), .rst(rst), .run(run),
      .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_data(pm_data), .pm_valid(pm_valid),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
      .acc(acc), .zero(zero), .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   // External ALU model
   function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5,
         3'd6:    return ~a;
         default: return a;
      endcase
   endfunction

   always_comb alu_out = alu_ref(alu_op, alu_a, alu_b);

   // Program memory responder: valid strobe in the lat-th cycle of a held read request
   always @(negedge clk) begin
      if (inj) pm_valid = 1'b1;
      else     pm_valid = pm_rd && (rd_cnt == lat - 1);
      pm_data = mem[pm_addr];
   end

   always @(posedge clk) begin
      if (pm_rd && !pm_valid) rd_cnt = rd_cnt + 1;
      else                    rd_cnt = 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      run = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic go();
      run = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic run_to_halt(output int cyc);
      cyc = 0;
      while (!halted && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("reach_halt", halted, 1);
   endtask

   task automatic fill_mem(input logic [7:0] b);
      for (int i = 0; i < 256; i++) mem[i] = b;
   endtask

   typedef struct {
      string      name;
      logic [127:0] prog;    // right-aligned, first byte most significant
      int         len;
      int         lat;
      logic [7:0] x_addr;
      logic [7:0] x_data;
      logic [7:0] exp_acc;
      logic       exp_z;
      logic [7:0] exp_pc;
      int         exp_cyc;
   } vec_t;

   vec_t vecs [7];

   task automatic load_vec(input vec_t v);
      fill_mem(8'hF0);
      for (int i = 0; i < v.len; i++) mem[i] = v.prog[8*(v.len-1-i) +: 8];
      mem[v.x_addr] = v.x_data;
   endtask

   task automatic random_run();
      logic [7:0] m_pc, m_acc, m_op, ir, b;
      logic [7:0] m_r [4];
      logic       m_z;
      logic [3:0] opc;
      bit         two;
      int         cyc;
      lat = $urandom_range(1, 4);
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b[7:4] == 4'hF && $urandom_range(0, 7) != 0) b[7:4] = 4'h9;
         mem[i] = b;
      end
      do_reset();
      go();
      m_pc = 8'h00; m_acc = 8'h00; m_z = 1'b0; m_op = 8'h00;
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      for (int k = 0; k < 25; k++) begin
         ir  = mem[m_pc];
         opc = ir[7:4];
         m_pc = m_pc + 8'd1;
         if (opc == 4'hF) begin
            repeat (lat + 1) @(posedge clk);
            #1;
            check("rnd_halted", halted, 1);
            check("rnd_halt_pc", pm_addr, m_pc);
            break;
         end
`ifdef ALU_SEQ_CTRL_JZ_EN
         two = (opc == 4'h9) || (opc == 4'hA) || (opc == 4'hB);
`else
         two = (opc == 4'h9) || (opc == 4'hA);
`endif
         cyc = lat + 2;
         if (two) begin
            m_op = mem[m_pc];
            m_pc = m_pc + 8'd1;
            cyc  = cyc + lat;
         end
         if (opc <= 4'd6) begin
            m_acc = alu_ref(opc[2:0], m_acc, m_r[ir[1:0]]);
            m_z   = (m_acc == 8'h00);
         end else if (opc == 4'h8) m_r[ir[1:0]] = m_acc;
         else if (opc == 4'h9) m_acc = m_op;
         else if (opc == 4'hA) m_pc = m_op;
`ifdef ALU_SEQ_CTRL_JZ_EN
         else if (opc == 4'hB && m_z) m_pc = m_op;
`endif
         repeat (cyc) @(posedge clk);
         #1;
         if (k == 0) run = 1'b0;  // execution must continue without run
         check("rnd_fetch_addr", {pm_rd, pm_addr}, {1'b1, m_pc});
         check("rnd_acc", acc, m_acc);
         check("rnd_zero", zero, m_z);
      end
   endtask

   initial begin
      int cyc;

      vecs[0] = '{"ldi_mov_sub", 128'h90_05_80_90_03_10_F0, 7, 1, 8'hFF, 8'hF0, 8'hFE, 1'b0, 8'h07, 16};
      vecs[1] = '{"logic_ops", 128'h90_07_81_31_21_51_61_F0, 8, 2, 8'hFF, 8'hF0, 8'h07, 1'b0, 8'h08, 29};
      vecs[2] = '{"zero_jmp", 128'h90_00_01_A0_10, 5, 1, 8'hFF, 8'hF0, 8'h00, 1'b1, 8'h11, 13};
      vecs[3] = '{"lat3", 128'h90_05_01_F0, 4, 3, 8'hFF, 8'hF0, 8'h05, 1'b0, 8'h04, 17};
`ifdef ALU_SEQ_CTRL_JZ_EN
      vecs[4] = '{"jz_taken", 128'h90_00_01_B0_08, 5, 1, 8'hFF, 8'hF0, 8'h00, 1'b1, 8'h09, 13};
      vecs[5] = '{"jz_not_taken", 128'h90_01_01_B0_08, 5, 1, 8'hFF, 8'hF0, 8'h01, 1'b0, 8'h06, 13};
`else
      vecs[4] = '{"b_nop_z1", 128'h90_00_01_B0_08, 5, 1, 8'hFF, 8'hF0, 8'h00, 1'b1, 8'h06, 15};
      vecs[5] = '{"b_nop_z0", 128'h90_01_01_B0_08, 5, 1, 8'hFF, 8'hF0, 8'h01, 1'b0, 8'h06, 15};
`endif
      vecs[6] = '{"pc_wrap", 128'hA0_FF, 2, 1, 8'hFF, 8'h90, 8'hA0, 1'b0, 8'h02, 10};

      // Reset state
      fill_mem(8'hF0);
      do_reset();
      check("rst_pm_rd", pm_rd, 0);
      check("rst_pm_addr", pm_addr, 8'h00);
      check("rst_alu_op", alu_op, 3'b110);
      check("rst_acc", acc, 8'h00);
      check("rst_zero", zero, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);

      // Reset mid-fetch, then a late strobe while idle
      mem[0] = 8'h90; mem[1] = 8'h33; mem[2] = 8'hF0;
      lat = 4;
      go();
      check("mid_fetch_rd", pm_rd, 1);
      check("fetch_busy", busy, 1);
      rst = 1'b1;
      run = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      inj = 1'b1;
      @(posedge clk); #1;
      inj = 1'b0;
      check("abort_pm_rd", pm_rd, 0);
      check("abort_pm_addr", pm_addr, 8'h00);
      check("abort_busy", busy, 0);
      lat = 1;
      go();
      run_to_halt(cyc);
      check("abort_restart_acc", acc, 8'h33);
      check("abort_restart_pc", pm_addr, 8'h03);

      // Read request held for the whole latency
      load_vec(vecs[3]);
      lat = 3;
      do_reset();
      go();
      for (int i = 0; i < 3; i++) begin
         check("lat3_rd_held", pm_rd, 1);
         @(posedge clk); #1;
      end
      check("lat3_rd_dropped", pm_rd, 0);
      check("lat3_decode_busy", busy, 1);
      run_to_halt(cyc);
      check("lat3_acc", acc, 8'h05);

      // Directed program table
      foreach (vecs[v]) begin
         load_vec(vecs[v]);
         lat = vecs[v].lat;
         do_reset();
         go();
         run_to_halt(cyc);
         check({vecs[v].name, "_cycles"}, cyc, vecs[v].exp_cyc);
         check({vecs[v].name, "_acc"}, acc, vecs[v].exp_acc);
         check({vecs[v].name, "_zero"}, zero, vecs[v].exp_z);
         check({vecs[v].name, "_pc"}, pm_addr, vecs[v].exp_pc);
         check({vecs[v].name, "_busy"}, busy, 0);
         check({vecs[v].name, "_alu_op"}, {pm_rd, alu_op}, {1'b0, 3'b110});
      end

      // Randomized programs against the instruction-level model
      for (int p = 0; p < 12; p++) random_run();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
